// File: rtl/dmem_pkg.sv
// Shared types and constants for the multi-cycle data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_e;

  // Smallest latency the FSM can express: one accept cycle plus the rdy cycle.
  localparam int LAT_MIN = 2;

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous word RAM with a registered read port.
// The contents are not reset; only the output register is.
module dmem_array #(
  parameter int AW = 12,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          wr,
  input  logic [AW-1:0] a,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] q
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (en && wr) begin
      mem[a] <= d;
    end
  end

  // q only moves on a read, so it holds the last read word across writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (en && !wr) begin
      q <= mem[a];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the CPU data port: captures a request in IDLE,
// waits a fixed latency, accesses the array on DONE entry and pulses rdy.
//
// Handshake: re/we are level requests sampled only in IDLE; the request is
// accepted in the cycle it is first seen there, stall stays high until the
// rdy cycle, and rdy is high for exactly one cycle per accepted request.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int DEPTH_LOG2 = 12,
  parameter int LAT        = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              re,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wrt_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              rdy,
  output logic              stall,
  output logic              err,
  output logic [1:0]        dbg_state
);

  localparam int CNT_W = (LAT > LAT_MIN) ? $clog2(LAT - 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LAT - LAT_MIN);

  if (LAT < LAT_MIN) begin : g_lat_chk
    $error("dmem_responder: LAT must be at least LAT_MIN");
  end
  if (ADDR_W <= DEPTH_LOG2) begin : g_addr_chk
    $error("dmem_responder: ADDR_W must exceed DEPTH_LOG2");
  end

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  op_e                   op_q, op_d;
  logic [DEPTH_LOG2-1:0] addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic                  oor_q, oor_d;
  logic                  err_q, err_d;
  logic                  zero_q;
  logic                  stall_raw;
  logic                  enter_done;
  logic                  req_oor;
  logic                  ram_en;
  logic [DATA_W-1:0]     ram_q;

  assign req_oor = |addr[ADDR_W-1:DEPTH_LOG2];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    oor_d      = oor_q;
    err_d      = err_q;
    stall_raw  = 1'b0;
    enter_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (re || we) begin
          stall_raw = 1'b1;
          op_d      = we ? OP_WR : OP_RD;
          addr_d    = addr[DEPTH_LOG2-1:0];
          wdata_d   = wrt_data;
          oor_d     = req_oor;
          err_d     = req_oor | (re & we);
          cnt_d     = CNT_LOAD;
          if (CNT_LOAD == '0) begin
            state_d    = DONE;
            enter_done = 1'b1;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        stall_raw = 1'b1;
        cnt_d     = cnt_q - 1'b1;
        if (cnt_d == '0) begin
          state_d    = DONE;
          enter_done = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= OP_RD;
      addr_q  <= '0;
      wdata_q <= '0;
      oor_q   <= 1'b0;
      err_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      oor_q   <= oor_d;
      err_q   <= err_d;
      // Out-of-range reads return zero without touching the array.
      if (enter_done && op_d == OP_RD) begin
        zero_q <= oor_d;
      end
    end
  end

  // The _d copies equal the captured values in BUSY and the live inputs when
  // IDLE jumps straight to DONE, so one path covers every latency.
  assign ram_en = enter_done & ~oor_d;

  dmem_array #(
    .AW(DEPTH_LOG2),
    .DW(DATA_W)
  ) u_array (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (ram_en),
    .wr   (op_d == OP_WR),
    .a    (addr_d),
    .d    (wdata_d),
    .q    (ram_q)
  );

  assign rd_data   = zero_q ? '0 : ram_q;
  assign rdy       = (state_q == DONE);
  assign err       = rdy & err_q;
  assign stall     = stall_raw & rst_n;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios plus random
// traffic, compared every cycle against a transaction-level memory model.
module tb_dmem_responder;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        re = 1'b0;
  logic        we = 1'b0;
  logic [15:0] addr = '0;
  logic [15:0] wrt_data = '0;
  logic [15:0] rd_data;
  logic        rdy;
  logic        stall;
  logic        err;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  dmem_responder #(
    .ADDR_W(16), .DATA_W(16), .DEPTH_LOG2(12), .LAT(LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .re(re), .we(we), .addr(addr),
    .wrt_data(wrt_data), .rd_data(rd_data), .rdy(rdy), .stall(stall),
    .err(err), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: a request seen while free is accepted at cycle
  // acc_cyc, stalls for LAT-1 cycles, completes at age LAT-1 and frees at LAT.
  logic [15:0] mem_m [int];
  int          cyc = 0;
  int          acc_cyc = 0;
  bit          active = 0;
  bit          m_wr, m_err;
  logic [15:0] m_addr, m_data;
  logic [15:0] exp_rd = '0;
  bit          exp_rd_known = 1;
  bit          exp_rdy, exp_stall, exp_err;
  int          stall_seen = 0;
  int          rdy_seen = 0;
  logic        last_err = 1'b0;

  always @(negedge clk) begin
    cyc++;
    exp_rdy = 0; exp_stall = 0; exp_err = 0;
    if (!rst_n) begin
      active = 0;
      exp_rd = '0;
      exp_rd_known = 1;
    end else begin
      if (active && (cyc - acc_cyc) >= LAT) active = 0;
      if (!active && (re || we)) begin
        active  = 1;
        acc_cyc = cyc;
        m_wr    = we;
        m_addr  = addr;
        m_data  = wrt_data;
        m_err   = (re && we) || (addr[15:12] != 4'h0);
      end
      if (active) begin
        if ((cyc - acc_cyc) <= LAT - 2) begin
          exp_stall = 1;
        end else begin
          exp_rdy = 1;
          exp_err = m_err;
          if (m_wr) begin
            if (m_addr[15:12] == 4'h0) mem_m[int'(m_addr)] = m_data;
          end else if (m_addr[15:12] != 4'h0) begin
            exp_rd = '0; exp_rd_known = 1;
          end else if (mem_m.exists(int'(m_addr))) begin
            exp_rd = mem_m[int'(m_addr)]; exp_rd_known = 1;
          end else begin
            exp_rd_known = 0;
          end
        end
      end
    end
    chk("stall", 32'(stall), 32'(exp_stall));
    chk("rdy", 32'(rdy), 32'(exp_rdy));
    if (exp_rdy || !rst_n) chk("err", 32'(err), 32'(exp_err));
    if (exp_rd_known) chk("rd_data", 32'(rd_data), 32'(exp_rd));
    if (stall) stall_seen++;
    if (rdy) begin
      rdy_seen++;
      last_err = err;
    end
  end

  task automatic idle(input int n);
    re = 0; we = 0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Presents a request for LAT cycles starting now (just after a rising edge).
  task automatic run_req(input logic r, input logic w, input logic [15:0] a,
                         input logic [15:0] d, input bit churn);
    re = r; we = w; addr = a; wrt_data = d;
    for (int i = 1; i < LAT; i++) begin
      @(posedge clk); #1;
      if (churn) begin
        re = 1'($urandom); we = 1'($urandom);
        addr = 16'($urandom); wrt_data = 16'($urandom);
      end
    end
    @(posedge clk); #1;
    re = 0; we = 0;
  endtask

  int s0, r0;

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2);
    chk("reset_rd_data", 32'(rd_data), 32'h0);
    chk("reset_stall", 32'(stall), 32'h0);

    // Write then read back.
    s0 = stall_seen; r0 = rdy_seen;
    run_req(0, 1, 16'h0010, 16'hBEEF, 0);
    chk("wr_stall_cycles", 32'(stall_seen - s0), 32'd2);
    chk("wr_rdy_pulses", 32'(rdy_seen - r0), 32'd1);
    chk("wr_err", 32'(last_err), 32'h0);
    run_req(1, 0, 16'h0010, 16'h0000, 0);
    chk("rd_beef", 32'(rd_data), 32'hBEEF);
    idle(2);
    chk("rd_beef_hold", 32'(rd_data), 32'hBEEF);

    // Out-of-range accesses.
    run_req(1, 0, 16'hF000, 16'h0000, 0);
    chk("oor_rd_err", 32'(last_err), 32'h1);
    chk("oor_rd_data", 32'(rd_data), 32'h0);
    run_req(0, 1, 16'h0005, 16'h2222, 0);
    run_req(0, 1, 16'h1005, 16'h1234, 0);
    chk("oor_wr_err", 32'(last_err), 32'h1);
    chk("oor_wr_rd_hold", 32'(rd_data), 32'h0);
    run_req(1, 0, 16'h0005, 16'h0000, 0);
    chk("oor_no_alias", 32'(rd_data), 32'h2222);

    // Simultaneous re and we behaves as a write with an error.
    run_req(1, 1, 16'h0020, 16'h00AA, 0);
    chk("illegal_err", 32'(last_err), 32'h1);
    run_req(1, 0, 16'h0020, 16'h0000, 0);
    chk("illegal_rd", 32'(rd_data), 32'h00AA);
    chk("illegal_rd_err", 32'(last_err), 32'h0);

    // Inputs churning after acceptance are ignored.
    run_req(0, 1, 16'h0041, 16'h0000, 0);
    re = 0; we = 1; addr = 16'h0040; wrt_data = 16'h7777;
    @(posedge clk); #1;
    we = 0; addr = 16'h0041; wrt_data = 16'h9999;
    @(posedge clk); #1;
    chk("churn_rdy", 32'(rdy), 32'h1);
    @(posedge clk); #1;
    run_req(1, 0, 16'h0040, 16'h0000, 0);
    chk("churn_rd_orig", 32'(rd_data), 32'h7777);
    run_req(1, 0, 16'h0041, 16'h0000, 0);
    chk("churn_rd_other", 32'(rd_data), 32'h0000);

    // Reset in BUSY drops the pending write.
    run_req(0, 1, 16'h0030, 16'h1111, 0);
    r0 = rdy_seen;
    re = 0; we = 1; addr = 16'h0030; wrt_data = 16'h5555;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rst_rdy", 32'(rdy), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_rd_data", 32'(rd_data), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(3);
    chk("rst_no_rdy", 32'(rdy_seen - r0), 32'h0);
    run_req(1, 0, 16'h0030, 16'h0000, 0);
    chk("rst_wr_dropped", 32'(rd_data), 32'h1111);

    // Random traffic over a small address pool.
    for (int t = 0; t < 150; t++) begin
      int kind;
      logic [15:0] a;
      kind = $urandom_range(0, 9);
      a = 16'($urandom_range(0, 15));
      if (kind == 9) a = a | 16'h1000 | 16'(($urandom_range(0, 14)) << 12);
      case (kind)
        0, 1, 2, 3: run_req(0, 1, a, 16'($urandom), 1'($urandom));
        8:          run_req(1, 1, a, 16'($urandom), 1'($urandom));
        9:          run_req(1'($urandom), 1, a, 16'($urandom), 1'($urandom));
        default:    run_req(1, 0, a, 16'($urandom), 1'($urandom));
      endcase
      idle($urandom_range(0, 2));
    end

    idle(3);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
